// File: rtl/clk_switch_seq_pkg.sv
// clk_seq_pkg: sequencer state encoding and clock-source codes.
package clk_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, FORCE_HSI, PARK, PLL_OFF, PLL_ON, LOCK, SEL_PATH, SWITCH, FINISH, FAIL
  } state_t;
  localparam logic [1:0] SRC_HSI  = 2'd0;
  localparam logic [1:0] SRC_HSE  = 2'd1;
  localparam logic [1:0] SRC_PLL  = 2'd2;
  localparam logic [1:0] SRC_RSVD = 2'd3;
endpackage

// File: rtl/clk_switch_seq_if.sv
// clk_switch_seq_if: request side and clock-control side of the switch sequencer.
interface clk_switch_seq_if;
  logic       req;
  logic [1:0] target;
  logic       pll_src_req;
  logic [1:0] pll_div_req;
  logic       div_en_req;
  logic       pll_lock;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] cur_src;
  logic       hsisel;
  logic       pllbypass;
  logic       divbypass;
  logic       pllsrc;
  logic [1:0] plldiv;
  logic       pll_cp_ena;
  logic       pll_vco_ena;
  modport master (
    output req, target, pll_src_req, pll_div_req, div_en_req, pll_lock,
    input  busy, done, err, cur_src, hsisel, pllbypass, divbypass, pllsrc, plldiv,
           pll_cp_ena, pll_vco_ena
  );
  modport slave (
    input  req, target, pll_src_req, pll_div_req, div_en_req, pll_lock,
    output busy, done, err, cur_src, hsisel, pllbypass, divbypass, pllsrc, plldiv,
           pll_cp_ena, pll_vco_ena
  );
endinterface

// File: rtl/clk_switch_seq_sync2.sv
// sync2: two-flop level synchronizer, async active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/clk_switch_seq.sv
// clk_switch_seq: steps the glitch-free mux chain and PLL enables through a fixed safe order
// so the system clock is always parked on HSI while anything upstream changes.
module clk_switch_seq
  import clk_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_TMO   = 4095,
  parameter int CNT_W      = 16
) (
  input  logic            clk1,
  input  logic            rst,
  clk_switch_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_TMO - 1);
  state_t           state;
  logic [CNT_W-1:0] tmr;
  logic [1:0]       tgt;
  logic             src_l;
  logic [1:0]       div_l;
  logic             den_l;
  logic             lock_s;
  logic             tmr_z;
  assign tmr_z = tmr == '0;
  sync2 u_sync (.clk(clk1), .rst(rst), .d(bus.pll_lock), .q(lock_s));
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      state           <= IDLE;
      tmr             <= '0;
      tgt             <= SRC_HSI;
      src_l           <= 1'b0;
      div_l           <= 2'd0;
      den_l           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.cur_src     <= SRC_HSI;
      bus.hsisel      <= 1'b0;
      bus.pllbypass   <= 1'b0;
      bus.divbypass   <= 1'b0;
      bus.pllsrc      <= 1'b0;
      bus.plldiv      <= 2'd0;
      bus.pll_cp_ena  <= 1'b0;
      bus.pll_vco_ena <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      tmr      <= tmr_z ? tmr : tmr - CNT_W'(1);
      case (state)
        IDLE:
          if (bus.req) begin
            if (bus.target == SRC_RSVD) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
            end else begin
              tgt         <= bus.target;
              src_l       <= bus.pll_src_req;
              div_l       <= bus.pll_div_req;
              den_l       <= bus.div_en_req;
              bus.err     <= 1'b0;
              bus.busy    <= 1'b1;
              bus.hsisel  <= 1'b0;
              bus.cur_src <= SRC_HSI;
              tmr         <= SETTLE_LD;
              state       <= FORCE_HSI;
            end
          end
        FORCE_HSI:
          if (tmr_z) begin
            bus.pllbypass <= 1'b0;
            tmr           <= SETTLE_LD;
            state         <= PARK;
          end
        PARK:
          if (tmr_z) begin
            bus.pll_cp_ena  <= 1'b0;
            bus.pll_vco_ena <= 1'b0;
            tmr             <= SETTLE_LD;
            state           <= PLL_OFF;
          end
        PLL_OFF:
          if (tmr_z) begin
            if (tgt == SRC_HSI) state <= FINISH;
            else if (tgt == SRC_HSE) begin
              bus.hsisel <= 1'b1;
              tmr        <= SETTLE_LD;
              state      <= SWITCH;
            end else begin
              // PLL is fully off here, so reference and divider may change safely
              bus.pllsrc <= src_l;
              bus.plldiv <= div_l;
              state      <= PLL_ON;
            end
          end
        PLL_ON: begin
          bus.pll_cp_ena  <= 1'b1;
          bus.pll_vco_ena <= 1'b1;
          tmr             <= LOCK_LD;
          state           <= LOCK;
        end
        LOCK:
          if (lock_s) begin
            bus.divbypass <= den_l;
            bus.pllbypass <= 1'b1;
            tmr           <= SETTLE_LD;
            state         <= SEL_PATH;
          end else if (tmr_z) state <= FAIL;
        SEL_PATH:
          if (tmr_z) begin
            bus.hsisel <= 1'b1;
            tmr        <= SETTLE_LD;
            state      <= SWITCH;
          end
        SWITCH:
          if (tmr_z) state <= FINISH;
        FINISH: begin
          bus.cur_src <= tgt;
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        FAIL: begin
          bus.pll_cp_ena  <= 1'b0;
          bus.pll_vco_ena <= 1'b0;
          bus.hsisel      <= 1'b0;
          bus.cur_src     <= SRC_HSI;
          bus.err         <= 1'b1;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_clk_switch_seq.sv
// tb_clk_switch_seq: randomized requests checked against a latency/outcome model of the sequencer.
module tb_clk_switch_seq;
  localparam int S   = 4;
  localparam int TMO = 100;
  logic clk1 = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] m_cur, m_pdiv;
  logic m_err, m_hsisel, m_pbyp, m_dbyp, m_psrc, m_pll;
  clk_switch_seq_if bus();
  clk_switch_seq #(.SETTLE_CYC(S), .LOCK_TMO(TMO), .CNT_W(16)) dut (
    .clk1(clk1), .rst(rst), .bus(bus)
  );
  always #5 clk1 = ~clk1;

  function automatic logic [11:0] obs();
    return {bus.cur_src, bus.err, bus.hsisel, bus.pllbypass, bus.divbypass, bus.pllsrc,
            bus.plldiv, bus.pll_cp_ena, bus.pll_vco_ena, bus.busy};
  endfunction

  function automatic logic [11:0] model();
    return {m_cur, m_err, m_hsisel, m_pbyp, m_dbyp, m_psrc, m_pdiv, m_pll, m_pll, 1'b0};
  endfunction

  task automatic model_clear();
    {m_cur, m_pdiv, m_err, m_hsisel, m_pbyp, m_dbyp, m_psrc, m_pll} = '0;
  endtask

  // d < 0: pll_lock never rises; otherwise it rises d cycles after vco_ena
  task automatic run_seq(input logic [1:0] t, input logic s, input logic [1:0] dv,
                         input logic de, input int d, input bit glitch);
    int lat, hsi_edge, gn, n;
    bit seen, trace_ok;
    lat = t == 3 ? 0 : t == 0 ? 3*S+1 : t == 1 ? 4*S+1 : d < 0 ? 3*S+1+TMO+1 : 5*S+1+(d+3)+1;
    hsi_edge = t == 1 ? 3*S : (t == 2 && d >= 0) ? 4*S+1+(d+3) : 1 << 30;
    gn = (glitch && t != 3) ? int'($urandom_range(lat - 1, 1)) : -1;
    bus.req = 1'b1;
    bus.target = t;
    bus.pll_src_req = s;
    bus.pll_div_req = dv;
    bus.div_en_req = de;
    bus.pll_lock = 1'b0;
    @(posedge clk1);
    n = 0;
    seen = 0;
    trace_ok = 1;
    while (!seen && n <= lat + 50) begin
      @(negedge clk1);
      bus.req = 1'b0;
      if (bus.done === 1'b1) seen = 1;
      else begin
        if (n < lat && (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.hsisel !== (n >= hsi_edge)))
          trace_ok = 0;
        if (n == gn) begin
          bus.req = 1'b1;
          bus.target = 2'($urandom_range(3, 0));
          bus.pll_src_req = 1'($urandom);
          bus.pll_div_req = 2'($urandom);
          bus.div_en_req = 1'($urandom);
        end
        if (t == 2 && d >= 0 && n == 3*S+1+d) bus.pll_lock = 1'b1;
        n++;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL latency t=%0d: done never seen, required at cycle %0d", t, lat);
    end else if (n != lat) begin
      miscompares++;
      $display("FAIL latency t=%0d: got %0d required %0d", t, n, lat);
    end
    if (t != 3) begin
      vectors++;
      if (!trace_ok) begin
        miscompares++;
        $display("FAIL trace t=%0d: busy/err/hsisel deviated during sequence", t);
      end
    end
    case (t)
      2'd0: {m_err, m_hsisel, m_pbyp, m_pll, m_cur} = {4'b0000, 2'd0};
      2'd1: {m_err, m_hsisel, m_pbyp, m_pll, m_cur} = {4'b0100, 2'd1};
      2'd2: begin
        m_psrc = s;
        m_pdiv = dv;
        if (d < 0) {m_err, m_hsisel, m_pbyp, m_pll, m_cur} = {4'b1000, 2'd0};
        else begin
          {m_err, m_hsisel, m_pbyp, m_pll, m_cur} = {4'b0111, 2'd2};
          m_dbyp = de;
        end
      end
      default: m_err = 1'b1;
    endcase
    vectors++;
    if (obs() !== model()) begin
      miscompares++;
      $display("FAIL final t=%0d: got %h required %h", t, obs(), model());
    end
    @(negedge clk1);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width t=%0d: done got %b required 0", t, bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {bus.req, bus.target, bus.pll_src_req, bus.pll_div_req, bus.div_en_req, bus.pll_lock} = '0;
    repeat (3) @(negedge clk1);
    vectors++;
    if (obs() !== 12'h000) begin
      miscompares++;
      $display("FAIL reset: got %h required 000", obs());
    end
    rst = 1'b0;
    repeat (5) @(negedge clk1);
    vectors++;
    if (obs() !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_idle: got %h required 000", obs());
    end
    model_clear();
  endtask

  task automatic test_pll_lock();
    run_seq(2'd2, 1'b1, 2'd2, 1'b1, 10, 1'b0);
  endtask

  task automatic test_pll_to_hse();
    run_seq(2'd1, 1'b0, 2'd0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_lock_timeout();
    run_seq(2'd2, 1'($urandom), 2'($urandom), 1'($urandom), -1, 1'b0);
    run_seq(2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reserved();
    run_seq(2'd3, 1'b1, 2'd3, 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq(2'd1, 1'b0, 2'd1, 1'b0, 0, 1'b1);
    run_seq(2'd2, 1'b0, 2'd3, 1'b1, int'($urandom_range(40, 0)), 1'b1);
    run_seq(2'd0, 1'b1, 2'd1, 1'b1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] t;
      int d;
      t = 2'($urandom_range(3, 0));
      d = (t == 2 && $urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(40, 0));
      run_seq(t, 1'($urandom), 2'($urandom), 1'($urandom), d, 1'($urandom));
    end
  endtask

  task automatic test_reset_in_lock();
    bus.req = 1'b1;
    bus.target = 2'd2;
    bus.pll_src_req = 1'b1;
    bus.pll_div_req = 2'd3;
    bus.div_en_req = 1'b1;
    bus.pll_lock = 1'b0;
    @(posedge clk1);
    repeat (3*S+6) begin
      @(negedge clk1);
      bus.req = 1'b0;
    end
    vectors++;
    if (bus.pll_vco_ena !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL in_lock: vco_ena=%b busy=%b required 1 1", bus.pll_vco_ena, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset: got %h required 000", obs());
    end
    @(negedge clk1);
    rst = 1'b0;
    model_clear();
    run_seq(2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pll_lock();
    test_pll_to_hse();
    test_lock_timeout();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_in_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
